// File: rtl/data_sram_responder_pkg.sv
// Shared encodings for the data-side SRAM responder and its strobe generator.
package data_sram_responder_pkg;

    // Access size as carried on the request's size field.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } sizeT;

    // Responder transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    // Legal range of the accept-to-response latency (fits the 4-bit counter).
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

endpackage

// File: rtl/data_sram_responder_strobe_gen.sv
// Byte-lane strobe and alignment check for byte/half/word accesses.
module sram_strobe_gen
    import data_sram_responder_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addrLo,
    output logic [3:0] strobe,
    output logic       misalign
);

    // Decode size and low address bits into lane enables; reserved size is an error.
    always_comb begin
        strobe   = '0;
        misalign = 1'b0;
        case (sizeT'(size))
            SZ_BYTE: strobe = 4'b0001 << addrLo;
            SZ_HALF: begin
                misalign = addrLo[0];
                strobe   = addrLo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                misalign = (addrLo != 2'b00);
                strobe   = '1;
            end
            default: misalign = 1'b1;
        endcase
        if (misalign) begin
            strobe = '0;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Single-outstanding SRAM-like responder serving loads/stores from an internal word array.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : gBadLatency
        $error("data_sram_responder: LATENCY must be within 1..15");
    end

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    stateT             state;
    logic [3:0]        count;
    logic              capWr;
    logic [1:0]        capSize;
    logic [ADDR_W+1:0] capAddr;
    logic [31:0]       capWdata;

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];

    logic              selWr;
    logic [1:0]        selSize;
    logic [ADDR_W+1:0] selAddr;
    logic [31:0]       selWdata;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        strobe;
    logic              misalign;
    logic              commit;
    logic              memWrite;

    // Upper address bits alias onto the array and are deliberately ignored.
    logic              unusedAddrHi;
    assign unusedAddrHi = ^addr[31:ADDR_W+2];

    assign addr_ok  = (state == IDLE);
    assign idx      = selAddr[ADDR_W+1:2];
    assign memWrite = rst && commit && selWr && !misalign;

    // With LATENCY = 1 the commit coincides with the accept edge, so the live
    // request is used there; otherwise the captured copy drives the commit.
    always_comb begin
        selWr    = capWr;
        selSize  = capSize;
        selAddr  = capAddr;
        selWdata = capWdata;
        if (state == IDLE) begin
            selWr    = wr;
            selSize  = size;
            selAddr  = addr[ADDR_W+1:0];
            selWdata = wdata;
        end
    end

    // Commit happens on the edge that moves the FSM into RESP.
    always_comb begin
        commit = 1'b0;
        if (LATENCY == 1) begin
            commit = (state == IDLE) && req;
        end else begin
            commit = (state == WAIT) && (count == 4'd1);
        end
    end

    sram_strobe_gen uStrobe (
        .size     (selSize),
        .addrLo   (selAddr[1:0]),
        .strobe   (strobe),
        .misalign (misalign)
    );

    // Byte-lane array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= selWdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM: accept in IDLE, count down in WAIT, one-cycle response in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            data_ok  <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            capWr    <= 1'b0;
            capSize  <= '0;
            capAddr  <= '0;
            capWdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        capWr    <= wr;
                        capSize  <= size;
                        capAddr  <= addr[ADDR_W+1:0];
                        capWdata <= wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            count <= '0;
                        end else begin
                            state <= WAIT;
                            count <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd1) begin
                        state <= RESP;
                        count <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    data_ok <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= '0;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                data_ok <= 1'b1;
                err     <= misalign;
                rdata   <= (misalign || selWr) ? '0 : mem[idx];
            end
        end
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Memory-side responder for the CPU data port: accepts one load/store request at a time on an SRAM-like req/addr_ok/data_ok handshake and serves it from an internal word-addressed array after a configurable latency. It is the slave end of the datapath's M-stage memory interface (address, write data, read data), so the pipeline can be verified against a non-zero-latency memory before the real bus bridge exists. Single outstanding transaction; byte/half/word accesses via lane strobes.

Parameters:
ADDR_W, 10, word-index width; array holds 2**ADDR_W 32-bit words
LATENCY, 2, cycles from accept edge to data_ok cycle; legal 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
req  in  1  request valid from CPU
wr  in  1  1 = store, 0 = load; sampled with req
size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
addr  in  32  byte address
wdata  in  32  store data, already lane-aligned by requester
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  one-cycle response pulse
rdata  out  32  full 32-bit word; valid only while data_ok = 1
err  out  1  misaligned or reserved-size request; valid only with data_ok

Behaviour:
- Only clk and rst are used; everything updates on the rising edge of clk.
- Reset (rst = 0 at an edge): state IDLE, latency counter 0, data_ok 0, err 0, rdata 0, captured request cleared.
- Array contents are not reset.
- A request in flight is dropped on reset, with no write and no data_ok.
- States:
  - IDLE: addr_ok = 1 (combinational on state only, independent of req). If req is high at the edge, capture wr/size/addr/wdata, load counter = LATENCY-1, then go to WAIT, or to RESP when LATENCY = 1.
  - WAIT: addr_ok = 0. Counter decrements each edge; on reaching 1, go to RESP.
  - RESP: addr_ok = 0, data_ok = 1 for exactly one cycle, then IDLE.
- The commit (array write, rdata capture) happens on the edge that enters RESP, so rdata/err are registered outputs.
- Timing: a request accepted at edge T0 gives data_ok high in the cycle after edge T0+LATENCY-1. The next accept is possible at the edge ending the RESP cycle + 1. Throughput is one request per LATENCY+1 cycles.
- Array index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo the array size.
- Strobe rules (bit i enables byte lane i = wdata[8i+7:8i]):
  - size 0: strobe = 1 << addr[1:0].
  - size 1: addr[0] must be 0; strobe 0011 if addr[1] = 0, else 1100.
  - size 2: addr[1:0] must be 00; strobe 1111.
  - size 3: error.
- Error (misalignment or size 3): err = 1 and rdata = 0 in the RESP cycle, and no array write.
- Store: bytes with strobe = 1 are written and other bytes are kept. rdata = 0, err = 0.
- Load: rdata = the whole stored word regardless of size. The CPU performs lane extraction and sign extension. err = 0.
- Load following a store to the same word: the load observes the stored data, because the store commits before the next accept.
- req held high across the response: a new accept occurs only in IDLE. A request presented during WAIT/RESP is ignored, not queued.
- Changing wr/size/addr/wdata after accept has no effect.

Decomposition:
- Shared package: size encodings (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2), FSM state encodings (IDLE, WAIT, RESP), and the LATENCY bounds.
- Sub-module sram_strobe_gen: combinational; inputs size and addr[1:0]; outputs strobe[3:0] and misalign. It is reused later by the CPU-side store-data aligner.
- The array is an inferred register/BRAM array inside data_sram_responder.

Test Plan:
- Reset/idle:
  - Stimulus: rst = 0 for 2 cycles, then 1 with req = 0.
  - Required: addr_ok = 1, data_ok = 0, rdata = 0, err = 0, and no state change over 10 cycles.
- Word store then load, LATENCY = 2:
  - Stimulus: store word 0xDEADBEEF to 0x100, then load 0x100.
  - Required: data_ok exactly 2 cycles after each accept edge; load rdata = 0xDEADBEEF, err = 0; addr_ok = 0 throughout WAIT/RESP.
- Byte/half merge:
  - Stimulus: preload word 0x11223344 at 0x200; byte store wdata 0xAAAAAAAA to 0x201; half store wdata 0xBBBBBBBB to 0x202; then load 0x200.
  - Required: rdata = 0xBBBBAA44.
- Misaligned:
  - Stimulus: half store to 0x301, word store to 0x302, and a size-3 request.
  - Required: each returns data_ok with err = 1 and rdata = 0; a following load of 0x300 returns the prior contents unchanged.
- Reset mid-operation:
  - Stimulus: accept a word store of 0x12345678 to 0x400 with LATENCY = 4; pull rst low one cycle after accept.
  - Required: no data_ok, state IDLE, and a later load of 0x400 returns the original value.
- LATENCY = 1 back-to-back with req held high and aliasing:
  - Stimulus: issue stores continuously; with ADDR_W = 10, store to 0x1000 and then load 0x0.
  - Required: accepts every 2 cycles; the load returns the data stored to 0x1000.
